rectifier: RTL and testbench
============================

// Module: rectifier
// PURPOSE
//   Activation stage between a node's result port and the next layer's argument lanes.
//   - Forward: clamps the signed Q8.8 node result to an unsigned Q0.8 argument byte (saturating ReLU).
//   - Train: takes the downstream error, gates it by the stored derivative, and returns it to the
//     upstream node's error port.
// PARAMETERS
//   IW          16  input (result/error/propagate) width, signed Q8.8
//   OW          8   output argument width, unsigned Q0.8
//   LEAK_SHIFT  4   arithmetic right shift applied to error in clamped regions (RECTIFIER_LEAK_EN only)
// PORTS
//   clock            in   1   single clock, all state on posedge
//   reset            in   1   asynchronous, active-high
//   train            in   1   sampled at argument acceptance; selects backward pass for that sample
//   argument_valid   in   1   upstream result valid
//   argument_data    in   IW  signed Q8.8 node result
//   argument_ready   out  1   ready for a new sample
//   result_valid     out  1   activated value valid
//   result_data      out  OW  unsigned Q0.8 activated value
//   result_ready     in   1   downstream accepts result
//   error_valid      in   1   downstream error valid
//   error_data       in   IW  signed Q8.8 error for the last result
//   error_ready      out  1   ready for error
//   propagate_valid  out  1   gated error valid
//   propagate_data   out  IW  signed Q8.8 gated error, to upstream node error port
//   propagate_ready  in   1   upstream accepts propagated error
// BEHAVIOUR
//   Reset values: state=ARG, argument_ready=1, result_valid=0, result_data=0, error_ready=0,
//     propagate_valid=0, propagate_data=0, stored input x=0, stored train flag=0.
//   Handshakes: transfer on posedge when valid&&ready. Valid is never dropped before transfer.
//     Data is stable while valid. No combinational path from any input to any ready/valid.
//   FSM:
//     ARG -> RES on argument transfer; latch x=argument_data and t=train.
//     RES: result_valid=1. Leaves RES on result transfer: to ERR if t, else to ARG.
//     ERR: error_ready=1. On error transfer -> PRP; latch gated error.
//     PRP: propagate_valid=1. On propagate transfer -> ARG.
//   Latency: result_valid asserts 1 cycle after argument transfer; propagate_valid 1 cycle after
//     error transfer. Ready is asserted only in its own state, so there is no overlap and
//     back-to-back streaming is 2 cycles per sample (4 when training).
//   Clamp (signed x):
//     x<=0           -> 8'h00
//     x>=16'sh0100   -> 8'hff
//     otherwise      -> x[7:0]
//   Derivative: pass region 16'sh0001..16'sh00ff gives propagate=error_data. Outside it, gives 0.
//   Error width: IW in, IW out, no growth. The leak shift is arithmetic, rounding toward -inf.
//   train changes outside ARG have no effect on the sample in flight.
//   Reset mid-operation: abort immediately to ARG, drop all valids, discard x and any pending error.
// CONFIGURATION
//   RECTIFIER_LEAK_EN
//     Defined:   clamped regions propagate error_data >>> LEAK_SHIFT instead of 0.
//                Forward output is unchanged.
//     Undefined: clamped regions propagate exactly 0. The LEAK_SHIFT parameter is unused.
// STRUCTURE
//   Shared package fixed_pkg:
//     - typedefs q8_8_t (logic signed [15:0]) and q0_8_t (logic [7:0]);
//     - state enum {ARG,RES,ERR,PRP};
//     - constants Q_ONE=16'sh0100 and Q0_MAX=8'hff;
//     - function clamp_q0_8().
//   No sub-module: one FSM, one input register, one output register each for result and propagate.
// TESTING
//   1. Reset 2 cycles, train=0, arg 16'h0040 -> result 8'h40 one cycle later.
//      Afterwards error_ready stays 0 and argument_ready returns to 1.
//   2. train=0, arg 16'hff80 -> result 8'h00. arg 16'h0123 -> result 8'hff. arg 16'h0000 -> 8'h00.
//   3. train=1, arg 16'h0040, error 16'h0010 -> propagate 16'h0010.
//      Same input with error 16'hfff0 -> propagate 16'hfff0.
//   4. train=1, arg 16'hfff0, error 16'h0010 -> propagate 16'h0000 without the macro.
//      With RECTIFIER_LEAK_EN: 16'h0001; error 16'hfff0 -> 16'hffff.
//   5. Hold result_ready=0 for 5 cycles -> result_valid and result_data stable, argument_ready=0.
//      Then release -> exactly one transfer.
//   6. Assert reset while in ERR -> error_ready drops and propagate_valid stays 0.
//      After release: argument_ready=1, and the next sample behaves as in scenario 1.

Source files
------------

// File: rtl/fixed_pkg.sv
// Fixed-point types, FSM state encoding and the Q8.8 -> Q0.8 saturating clamp
// shared by the activation datapath.
package fixed_pkg;

    typedef logic signed [15:0] q8_8_t;
    typedef logic        [7:0]  q0_8_t;

    typedef enum logic [1:0] {ARG, RES, ERR, PRP} state_t;

    localparam q8_8_t Q_ONE  = 16'sh0100;
    localparam q0_8_t Q0_MAX = 8'hff;

    function automatic q0_8_t clamp_q0_8(input q8_8_t x);
        if (x <= 16'sh0000)
            return 8'h00;
        else if (x >= Q_ONE)
            return Q0_MAX;
        else
            return x[7:0];
    endfunction

endpackage

// File: rtl/rectifier.sv
// Saturating ReLU activation with a gated backward error path.
// Optional macro RECTIFIER_LEAK_EN: clamped regions leak error >>> LEAK_SHIFT instead of 0.
module rectifier
    import fixed_pkg::*;
#(
    parameter int IW         = 16,
    parameter int OW         = 8,
    parameter int LEAK_SHIFT = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 train,
    input  logic                 argument_valid,
    input  logic signed [IW-1:0] argument_data,
    output logic                 argument_ready,
    output logic                 result_valid,
    output logic        [OW-1:0] result_data,
    input  logic                 result_ready,
    input  logic                 error_valid,
    input  logic signed [IW-1:0] error_data,
    output logic                 error_ready,
    output logic                 propagate_valid,
    output logic signed [IW-1:0] propagate_data,
    input  logic                 propagate_ready
);

`ifdef RECTIFIER_LEAK_EN
    localparam bit LEAK_EN = 1'b1;
`else
    localparam bit LEAK_EN = 1'b0;
`endif

    state_t               r_state_p0;
    state_t               w_next_state;
    q8_8_t                r_x_p0;
    logic                 r_t_p0;
    q0_8_t                r_res_p1;
    logic signed [IW-1:0] r_prp_p1;
    logic                 w_arg_xfer;
    logic                 w_err_xfer;

    // Derivative gate: pass strictly inside (0, 1.0); leak or zero elsewhere.
    function automatic logic signed [IW-1:0] gate_error(input q8_8_t x,
                                                        input logic signed [IW-1:0] e);
        if (x > 16'sh0000 && x < Q_ONE)
            return e;
        else if (LEAK_EN)
            return e >>> LEAK_SHIFT;
        else
            return '0;
    endfunction

    assign argument_ready  = (r_state_p0 == ARG);
    assign result_valid    = (r_state_p0 == RES);
    assign error_ready     = (r_state_p0 == ERR);
    assign propagate_valid = (r_state_p0 == PRP);
    assign result_data     = r_res_p1;
    assign propagate_data  = r_prp_p1;

    assign w_arg_xfer = argument_valid && (r_state_p0 == ARG);
    assign w_err_xfer = error_valid && (r_state_p0 == ERR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state_p0 <= ARG;
        else
            r_state_p0 <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state_p0;
        case (r_state_p0)
            ARG: if (argument_valid)  w_next_state = RES;
            RES: if (result_ready)    w_next_state = r_t_p0 ? ERR : ARG;
            ERR: if (error_valid)     w_next_state = PRP;
            PRP: if (propagate_ready) w_next_state = ARG;
            default:                  w_next_state = ARG;
        endcase
    end

    // p0 -> p1: capture input sample and its activated value
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x_p0   <= '0;
            r_t_p0   <= 1'b0;
            r_res_p1 <= '0;
        end else if (w_arg_xfer) begin
            r_x_p0   <= argument_data;
            r_t_p0   <= train;
            r_res_p1 <= clamp_q0_8(argument_data);
        end
    end

    // p0 -> p1: gated error toward the upstream node
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_prp_p1 <= '0;
        else if (w_err_xfer)
            r_prp_p1 <= gate_error(r_x_p0, error_data);
    end

endmodule

// File: tb/tb_rectifier.sv
// Self-checking bench for rectifier: directed vector table, corner sequences, random vs model.
module tb_rectifier;

`ifdef RECTIFIER_LEAK_EN
    localparam bit LEAK = 1'b1;
`else
    localparam bit LEAK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        train = 1'b0;
    logic        argument_valid = 1'b0;
    logic [15:0] argument_data = '0;
    logic        argument_ready;
    logic        result_valid;
    logic [7:0]  result_data;
    logic        result_ready = 1'b0;
    logic        error_valid = 1'b0;
    logic [15:0] error_data = '0;
    logic        error_ready;
    logic        propagate_valid;
    logic [15:0] propagate_data;
    logic        propagate_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_res_xfer = 0;

    rectifier dut (
        .clock          (clock),
        .reset          (reset),
        .train          (train),
        .argument_valid (argument_valid),
        .argument_data  (argument_data),
        .argument_ready (argument_ready),
        .result_valid   (result_valid),
        .result_data    (result_data),
        .result_ready   (result_ready),
        .error_valid    (error_valid),
        .error_data     (error_data),
        .error_ready    (error_ready),
        .propagate_valid(propagate_valid),
        .propagate_data (propagate_data),
        .propagate_ready(propagate_ready)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (result_valid && result_ready) n_res_xfer++;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        trn;
        logic [15:0] arg;
        logic [15:0] err;
        logic [7:0]  exp_res;
        logic [15:0] exp_prp;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model from the activation rules, using plain integer arithmetic.
    function automatic logic [7:0] model_res(input logic [15:0] a);
        int v;
        v = int'($signed(a));
        if (v <= 0)   return 8'h00;
        if (v >= 256) return 8'hff;
        return v[7:0];
    endfunction

    function automatic logic [15:0] model_prp(input logic [15:0] a, input logic [15:0] e);
        int x;
        int ev;
        int q;
        x  = int'($signed(a));
        ev = int'($signed(e));
        if (x >= 1 && x <= 255) return e;
        if (!LEAK) return 16'h0000;
        q = ev / 16;
        if ((ev % 16) != 0 && ev < 0) q = q - 1;
        return q[15:0];
    endfunction

    task automatic run_sample(input string nm, input logic trn, input logic [15:0] a,
                              input logic [15:0] e, input logic [7:0] er,
                              input logic [15:0] ep, input int stall);
        int n;
        int x0;
        n = 0;
        while (!argument_ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check({nm, ".arg_ready"}, {31'b0, argument_ready}, 32'd1);
        if (!argument_ready) return;
        argument_valid = 1'b1;
        argument_data  = a;
        train          = trn;
        @(posedge clock); #1;
        argument_valid = 1'b0;
        argument_data  = 16'($urandom);
        train          = ~trn;
        check({nm, ".res_valid"}, {31'b0, result_valid}, 32'd1);
        check({nm, ".res_data"}, {24'b0, result_data}, {24'b0, er});
        check({nm, ".arg_busy"}, {31'b0, argument_ready}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clock); #1;
            check({nm, ".stall_valid"}, {31'b0, result_valid}, 32'd1);
            check({nm, ".stall_data"}, {24'b0, result_data}, {24'b0, er});
            check({nm, ".stall_arg"}, {31'b0, argument_ready}, 32'd0);
        end
        x0 = n_res_xfer;
        result_ready = 1'b1;
        @(posedge clock); #1;
        result_ready = 1'b0;
        check({nm, ".res_xfer"}, n_res_xfer - x0, 32'd1);
        check({nm, ".res_drop"}, {31'b0, result_valid}, 32'd0);
        if (trn) begin
            check({nm, ".err_ready"}, {31'b0, error_ready}, 32'd1);
            error_valid = 1'b1;
            error_data  = e;
            @(posedge clock); #1;
            error_valid = 1'b0;
            error_data  = 16'($urandom);
            check({nm, ".err_done"}, {31'b0, error_ready}, 32'd0);
            check({nm, ".prp_valid"}, {31'b0, propagate_valid}, 32'd1);
            check({nm, ".prp_data"}, {16'b0, propagate_data}, {16'b0, ep});
            propagate_ready = 1'b1;
            @(posedge clock); #1;
            propagate_ready = 1'b0;
            check({nm, ".prp_drop"}, {31'b0, propagate_valid}, 32'd0);
        end else begin
            check({nm, ".no_err"}, {31'b0, error_ready}, 32'd0);
        end
        check({nm, ".arg_back"}, {31'b0, argument_ready}, 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        logic [15:0] a;
        logic [15:0] e;
        logic        t;
        int          k;

        vecs.push_back('{"s1",   1'b0, 16'h0040, 16'h0000, 8'h40, 16'h0000});
        vecs.push_back('{"s2a",  1'b0, 16'hff80, 16'h0000, 8'h00, 16'h0000});
        vecs.push_back('{"s2b",  1'b0, 16'h0123, 16'h0000, 8'hff, 16'h0000});
        vecs.push_back('{"s2c",  1'b0, 16'h0000, 16'h0000, 8'h00, 16'h0000});
        vecs.push_back('{"s3a",  1'b1, 16'h0040, 16'h0010, 8'h40, 16'h0010});
        vecs.push_back('{"s3b",  1'b1, 16'h0040, 16'hfff0, 8'h40, 16'hfff0});
        vecs.push_back('{"s4a",  1'b1, 16'hfff0, 16'h0010, 8'h00, LEAK ? 16'h0001 : 16'h0000});
        vecs.push_back('{"s4b",  1'b1, 16'hfff0, 16'hfff0, 8'h00, LEAK ? 16'hffff : 16'h0000});
        vecs.push_back('{"lo1",  1'b1, 16'h0001, 16'h1234, 8'h01, 16'h1234});
        vecs.push_back('{"hi1",  1'b1, 16'h00ff, 16'h8001, 8'hff, 16'h8001});
        vecs.push_back('{"one",  1'b1, 16'h0100, 16'h0100, 8'hff, LEAK ? 16'h0010 : 16'h0000});
        vecs.push_back('{"zero", 1'b1, 16'h0000, 16'h0123, 8'h00, LEAK ? 16'h0012 : 16'h0000});
        vecs.push_back('{"min",  1'b1, 16'h8000, 16'h8000, 8'h00, LEAK ? 16'hf800 : 16'h0000});
        vecs.push_back('{"max",  1'b1, 16'h7fff, 16'hffff, 8'hff, LEAK ? 16'hffff : 16'h0000});

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst.arg_ready", {31'b0, argument_ready}, 32'd1);
        check("rst.res_valid", {31'b0, result_valid}, 32'd0);
        check("rst.res_data", {24'b0, result_data}, 32'd0);
        check("rst.err_ready", {31'b0, error_ready}, 32'd0);
        check("rst.prp_valid", {31'b0, propagate_valid}, 32'd0);
        check("rst.prp_data", {16'b0, propagate_data}, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        foreach (vecs[i])
            run_sample(vecs[i].name, vecs[i].trn, vecs[i].arg, vecs[i].err,
                       vecs[i].exp_res, vecs[i].exp_prp, 0);

        // Backpressure on the result port
        run_sample("stall", 1'b0, 16'h0077, 16'h0000, 8'h77, 16'h0000, 5);

        // Reset while waiting for the error
        argument_valid = 1'b1;
        argument_data  = 16'h0040;
        train          = 1'b1;
        @(posedge clock); #1;
        argument_valid = 1'b0;
        result_ready   = 1'b1;
        @(posedge clock); #1;
        result_ready   = 1'b0;
        check("r6.in_err", {31'b0, error_ready}, 32'd1);
        error_data  = 16'h0010;
        #1 reset = 1'b1;
        error_valid = 1'b1;
        #1;
        check("r6.err_drop", {31'b0, error_ready}, 32'd0);
        check("r6.prp_idle", {31'b0, propagate_valid}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        check("r6.prp_hold", {31'b0, propagate_valid}, 32'd0);
        check("r6.prp_data", {16'b0, propagate_data}, 32'd0);
        reset       = 1'b0;
        error_valid = 1'b0;
        @(posedge clock); #1;
        check("r6.prp_after", {31'b0, propagate_valid}, 32'd0);
        check("r6.arg_ready", {31'b0, argument_ready}, 32'd1);
        run_sample("r6.s1", 1'b0, 16'h0040, 16'h0000, 8'h40, 16'h0000, 0);

        // Random samples against the reference model
        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 3);
            case (k)
                0:       a = 16'($urandom);
                1:       a = 16'($urandom_range(0, 16'h01ff));
                2:       a = 16'($signed(6'($urandom_range(0, 8))) - 16'sd4);
                default: a = 16'($urandom_range(16'h00f0, 16'h0110));
            endcase
            e = 16'($urandom);
            t = 1'($urandom);
            run_sample("rnd", t, a, e, model_res(a), model_prp(a, e), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
